// File: rtl/debouncer_multi_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Package     : debounce_pkg
// | Description : Shared constants and width helpers for the multi-channel
// |               switch debouncer.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
package debounce_pkg;

    localparam int c_SIM_DEBOUNCE_CYCLES   = 8;
    localparam int c_BOARD_DEBOUNCE_CYCLES = 65536;
    localparam int c_BOARD_HOLD_CYCLES     = 1048576;

    // Counter width able to hold 0..cycles-1; never narrower than one bit.
    function automatic int count_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debouncer_multi_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Interface   : debouncer_multi_if
// | Description : Pin-side inputs and front-panel-side outputs of the
// |               multi-channel debouncer.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
interface debouncer_multi_if #(
    parameter int CHANNELS = 4
);

    logic [CHANNELS-1:0] switch_input;
    logic [CHANNELS-1:0] state;
    logic [CHANNELS-1:0] trans_up;
    logic [CHANNELS-1:0] trans_dn;
    logic [CHANNELS-1:0] hold;
    logic                any_event;

    // Board/control side: drives the raw pins, consumes the debounced view.
    modport master (
        output switch_input,
        input  state,
        input  trans_up,
        input  trans_dn,
        input  hold,
        input  any_event
    );

    // Debouncer side.
    modport slave (
        input  switch_input,
        output state,
        output trans_up,
        output trans_dn,
        output hold,
        output any_event
    );

endinterface : debouncer_multi_if
`default_nettype wire

// File: rtl/debouncer_multi_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : debounce_chan
// | Description : One debounce channel: stability counter, accepted level,
// |               rise/fall pulses and (with DEBOUNCE_HOLD_EN) long-press pulse.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = c_BOARD_DEBOUNCE_CYCLES,
`ifdef DEBOUNCE_HOLD_EN
    parameter int   HOLD_CYCLES     = c_BOARD_HOLD_CYCLES,
`endif
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic i_lvl,
    output logic o_state,
    output logic o_trans_up,
    output logic o_trans_dn,
    output logic o_hold
);

    localparam int              c_CW       = count_width(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0] c_CNT_TERM = c_CW'(DEBOUNCE_CYCLES - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_state;
    logic            r_trans_up;
    logic            r_trans_dn;

    // Any sample matching the accepted level restarts the stability window.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cnt      <= '0;
            r_state    <= RESET_VAL;
            r_trans_up <= 1'b0;
            r_trans_dn <= 1'b0;
        end else begin
            r_trans_up <= 1'b0;
            r_trans_dn <= 1'b0;
            if (i_lvl == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_TERM) begin
                r_cnt      <= '0;
                r_state    <= i_lvl;
                r_trans_up <= i_lvl;
                r_trans_dn <= ~i_lvl;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_state    = r_state;
    assign o_trans_up = r_trans_up;
    assign o_trans_dn = r_trans_dn;

`ifdef DEBOUNCE_HOLD_EN
    localparam int              c_HW        = count_width(HOLD_CYCLES);
    localparam logic [c_HW-1:0] c_HOLD_TERM = c_HW'(HOLD_CYCLES - 1);

    logic [c_HW-1:0] r_hold_cnt;
    logic            r_hold_done;
    logic            r_hold;

    // Saturating press timer; r_hold_done blocks re-firing until release.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_hold_cnt  <= '0;
            r_hold_done <= 1'b0;
            r_hold      <= 1'b0;
        end else if (!r_state) begin
            r_hold_cnt  <= '0;
            r_hold_done <= 1'b0;
            r_hold      <= 1'b0;
        end else if (r_hold_cnt != c_HOLD_TERM) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
            r_hold     <= 1'b0;
        end else begin
            r_hold      <= ~r_hold_done;
            r_hold_done <= 1'b1;
        end
    end

    assign o_hold = r_hold;
`else
    assign o_hold = 1'b0;
`endif

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debouncer_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : debouncer_multi
// | Description : N-channel switch debouncer with per-channel polarity, edge
// |               pulses and an aggregate event strobe. Long-press pulses are
// |               built only when DEBOUNCE_HOLD_EN is defined.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  DEBOUNCE_CYCLES = c_BOARD_DEBOUNCE_CYCLES,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '0,
    parameter logic [CHANNELS-1:0] RESET_STATE     = '0,
    parameter int                  HOLD_CYCLES     = c_BOARD_HOLD_CYCLES
) (
    input  logic              CLK,
    input  logic              RESETN,
    debouncer_multi_if.slave  bus
);

    if (CHANNELS < 1 || CHANNELS > 32) begin : g_err_channels
        $error("debouncer_multi: CHANNELS must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_err_debounce
        $error("debouncer_multi: DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 2) begin : g_err_hold
        $error("debouncer_multi: HOLD_CYCLES must be >= 2");
    end

    // Pin-level reset image, so the synchroniser agrees with the reset state.
    localparam logic [CHANNELS-1:0] c_SYNC_RESET = RESET_STATE ^ ACTIVE_LOW_MASK;

    logic [CHANNELS-1:0] r_sync_0;
    logic [CHANNELS-1:0] r_sync_1;
    logic [CHANNELS-1:0] w_lvl;
    logic [CHANNELS-1:0] w_state;
    logic [CHANNELS-1:0] w_trans_up;
    logic [CHANNELS-1:0] w_trans_dn;
    logic [CHANNELS-1:0] w_hold;
    logic                r_any_event;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_sync_0    <= c_SYNC_RESET;
            r_sync_1    <= c_SYNC_RESET;
            r_any_event <= 1'b0;
        end else begin
            r_sync_0    <= bus.switch_input;
            r_sync_1    <= r_sync_0;
            r_any_event <= |(w_trans_up | w_trans_dn);
        end
    end

    assign w_lvl = r_sync_1 ^ ACTIVE_LOW_MASK;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef DEBOUNCE_HOLD_EN
            .HOLD_CYCLES     (HOLD_CYCLES),
`endif
            .RESET_VAL       (RESET_STATE[gi])
        ) u_chan (
            .CLK        (CLK),
            .RESETN     (RESETN),
            .i_lvl      (w_lvl[gi]),
            .o_state    (w_state[gi]),
            .o_trans_up (w_trans_up[gi]),
            .o_trans_dn (w_trans_dn[gi]),
            .o_hold     (w_hold[gi])
        );
    end

    assign bus.state     = w_state;
    assign bus.trans_up  = w_trans_up;
    assign bus.trans_dn  = w_trans_dn;
    assign bus.hold      = w_hold;
    assign bus.any_event = r_any_event;

endmodule : debouncer_multi
`default_nettype wire
